// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: issues one doubleword-aligned bus access per instruction,
// lane-aligns store data, extracts and extends load data, and aborts on bad access or timeout.
module mem_access_ctrl #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_valid,
  input  logic            load_data,
  input  logic            store_data,
  input  logic [2:0]      funct3,
  input  logic [7:0]      wmask,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  input  logic            flush,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [7:0]      mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            stall,
  output logic [XLEN-1:0] rdata,
  output logic            rdata_valid,
  output logic            access_err
);
  typedef enum logic [1:0] {StIdle, StAccess, StDone, StErr} state_e;
  state_e state_q, state_d;

  logic [7:0]      cnt_q;
  logic [2:0]      off_q, funct3_q;
  logic            is_load_q, flushed_q, we_q;
  logic [7:0]      be_q;
  logic [XLEN-1:0] addr_q, wdata_q, rdata_q;

  logic [2:0]      off;
  logic [3:0]      size;
  logic [7:0]      size_mask;
  logic            launch, both, reject;
  logic [XLEN-1:0] rd_shift, rd_ext;

  assign off = addr[2:0];

  // Access size in bytes; zero marks a funct3 unsupported for the direction.
  always_comb begin
    size = 4'd0;
    if (load_data) begin
      case (funct3)
        3'b011:         size = 4'd8;
        3'b010, 3'b110: size = 4'd4;
        3'b001, 3'b101: size = 4'd2;
        default:        size = 4'd0;
      endcase
    end else begin
      case (funct3)
        3'b011:  size = 4'd8;
        3'b010:  size = 4'd4;
        3'b001:  size = 4'd2;
        default: size = 4'd0;
      endcase
    end
  end

  always_comb begin
    case (size)
      4'd8:    size_mask = 8'hFF;
      4'd4:    size_mask = 8'h0F;
      4'd2:    size_mask = 8'h03;
      default: size_mask = 8'h00;
    endcase
  end

  assign launch = mem_valid & ~flush & (load_data ^ store_data);
  assign both   = mem_valid & load_data & store_data;
  assign reject = (size == 4'd0) || (({1'b0, off} + size) > 4'd8)
                  || (store_data && (wmask != size_mask));

  assign rd_shift = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    case (funct3_q)
      3'b010:  rd_ext = {{(XLEN-32){rd_shift[31]}}, rd_shift[31:0]};
      3'b110:  rd_ext = {{(XLEN-32){1'b0}}, rd_shift[31:0]};
      3'b001:  rd_ext = {{(XLEN-16){rd_shift[15]}}, rd_shift[15:0]};
      3'b101:  rd_ext = {{(XLEN-16){1'b0}}, rd_shift[15:0]};
      default: rd_ext = rd_shift;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (both)        state_d = StErr;
        else if (launch) state_d = reject ? StErr : StAccess;
      end
      StAccess: begin
        if (mem_ack)                         state_d = StDone;
        else if (cnt_q == 8'(TIMEOUT - 1))   state_d = StErr;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      off_q     <= '0;
      funct3_q  <= '0;
      is_load_q <= 1'b0;
      flushed_q <= 1'b0;
      we_q      <= 1'b0;
      be_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else if (state_q == StIdle && state_d == StAccess) begin
      addr_q    <= {addr[XLEN-1:3], 3'b000};
      off_q     <= off;
      funct3_q  <= funct3;
      is_load_q <= load_data;
      we_q      <= store_data;
      be_q      <= (store_data ? wmask : size_mask) << off;
      wdata_q   <= wdata << {off, 3'b000};
      cnt_q     <= '0;
      flushed_q <= 1'b0;
    end else if (state_q == StAccess) begin
      // A squash mid-access lets the bus transaction finish but hides its result.
      if (flush) flushed_q <= 1'b1;
      if (mem_ack) begin
        if (is_load_q) rdata_q <= rd_ext;
      end else begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    mem_req     = 1'b0;
    stall       = 1'b0;
    rdata_valid = 1'b0;
    access_err  = 1'b0;
    case (state_q)
      StIdle:   stall = launch;
      StAccess: begin
        mem_req = 1'b1;
        stall   = 1'b1;
      end
      StDone:   rdata_valid = is_load_q & ~flushed_q;
      StErr:    access_err = 1'b1;
      default:  ;
    endcase
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl: a transaction-level model derives per-cycle expectations
// from byte-lane arithmetic, and one negedge process compares every DUT output against them.
module tb_mem_access_ctrl;
  localparam int unsigned XLEN    = 64;
  localparam int unsigned TIMEOUT = 15;

  logic            clk = 1'b0;
  logic            rst;
  logic            mem_valid, load_data, store_data, flush, mem_ack;
  logic [2:0]      funct3;
  logic [7:0]      wmask;
  logic [XLEN-1:0] addr, wdata, mem_rdata;
  logic            mem_req, mem_we, stall, rdata_valid, access_err;
  logic [XLEN-1:0] mem_addr, mem_wdata, rdata;
  logic [7:0]      mem_be;

  mem_access_ctrl #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_valid  (mem_valid),
    .load_data  (load_data),
    .store_data (store_data),
    .funct3     (funct3),
    .wmask      (wmask),
    .addr       (addr),
    .wdata      (wdata),
    .flush      (flush),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .stall      (stall),
    .rdata      (rdata),
    .rdata_valid(rdata_valid),
    .access_err (access_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  logic        exp_req, exp_stall, exp_rv, exp_err, exp_we, exp_zero;
  logic [63:0] exp_addr, exp_wdata, exp_rdata;
  logic [7:0]  exp_be;

  logic        pin_acc_en = 1'b0, pin_wd_en = 1'b0, pin_rd_en = 1'b0;
  logic [63:0] pin_addr, pin_wdata, pin_rdata;
  logic [7:0]  pin_be;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("mem_req", 64'(mem_req), 64'(exp_req));
      check("stall", 64'(stall), 64'(exp_stall));
      check("rdata_valid", 64'(rdata_valid), 64'(exp_rv));
      check("access_err", 64'(access_err), 64'(exp_err));
      if (exp_req) begin
        check("mem_we", 64'(mem_we), 64'(exp_we));
        check("mem_addr", mem_addr, exp_addr);
        check("mem_be", 64'(mem_be), 64'(exp_be));
        check("mem_wdata", mem_wdata, exp_wdata);
        if (pin_acc_en) begin
          check("lit_mem_addr", mem_addr, pin_addr);
          check("lit_mem_be", 64'(mem_be), 64'(pin_be));
        end
        if (pin_wd_en) check("lit_mem_wdata", mem_wdata, pin_wdata);
      end
      if (exp_rv) begin
        check("rdata", rdata, exp_rdata);
        if (pin_rd_en) check("lit_rdata", rdata, pin_rdata);
      end
      if (exp_zero) begin
        check("zero_mem_we", 64'(mem_we), 64'd0);
        check("zero_mem_addr", mem_addr, 64'd0);
        check("zero_mem_be", 64'(mem_be), 64'd0);
        check("zero_mem_wdata", mem_wdata, 64'd0);
        check("zero_rdata", rdata, 64'd0);
      end
    end
  end

  function automatic int size_of(input bit ld, input logic [2:0] f3);
    if (ld) begin
      if (f3 == 3'b011) return 8;
      if (f3 == 3'b010 || f3 == 3'b110) return 4;
      if (f3 == 3'b001 || f3 == 3'b101) return 2;
    end else begin
      if (f3 == 3'b011) return 8;
      if (f3 == 3'b010) return 4;
      if (f3 == 3'b001) return 2;
    end
    return 0;
  endfunction

  // Start of a cycle: random don't-care inputs that must never launch, idle expectations.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    rst       = 1'b0;
    mem_valid = 1'($urandom);
    if (mem_valid) begin
      flush      = 1'b1;
      load_data  = 1'($urandom);
      store_data = ~load_data;
    end else begin
      flush      = 1'($urandom);
      load_data  = 1'($urandom);
      store_data = 1'($urandom);
    end
    funct3    = 3'($urandom);
    wmask     = 8'($urandom);
    addr      = {$urandom, $urandom};
    wdata     = {$urandom, $urandom};
    mem_rdata = {$urandom, $urandom};
    mem_ack   = 1'($urandom);
    exp_req   = 1'b0;
    exp_stall = 1'b0;
    exp_rv    = 1'b0;
    exp_err   = 1'b0;
    exp_we    = 1'b0;
    exp_zero  = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
    pin_acc_en = 1'b0;
    pin_wd_en  = 1'b0;
    pin_rd_en  = 1'b0;
  endtask

  task automatic run_op(input bit ld, input bit st, input logic [2:0] f3, input logic [7:0] wm,
                        input logic [63:0] a, input logic [63:0] wd, input logic [63:0] rd,
                        input int ack_dly, input int fl_cyc, input int rst_cyc);
    int          sz, off;
    bit          rej, flushed;
    logic [7:0]  be;
    logic [63:0] wlane, rv;
    off = int'(a[2:0]);
    sz  = size_of(ld, f3);
    rej = (ld && st) || (sz == 0) || (off + sz > 8) || (st && wm != 8'((1 << sz) - 1));
    be = '0;
    wlane = '0;
    rv = '0;
    if (!rej) begin
      for (int b = 0; b < 8; b++) begin
        if (b >= off && b < off + sz) be[b] = st ? wm[b-off] : 1'b1;
        if (b >= off) wlane[8*b +: 8] = wd[8*(b-off) +: 8];
      end
      for (int b = 0; b < sz; b++) rv[8*b +: 8] = rd[8*(off+b) +: 8];
      if (!f3[2] && sz < 8 && rv[8*sz-1])
        for (int b = sz; b < 8; b++) rv[8*b +: 8] = 8'hFF;
    end

    next_cycle();
    mem_valid  = 1'b1;
    load_data  = ld;
    store_data = st;
    funct3     = f3;
    wmask      = wm;
    addr       = a;
    wdata      = wd;
    flush      = 1'b0;
    exp_stall  = ld ^ st;
    if (rej) begin
      next_cycle();
      exp_err = 1'b1;
      return;
    end
    flushed = 1'b0;
    for (int i = 0; i <= int'(TIMEOUT); i++) begin
      next_cycle();
      flush   = (i == fl_cyc);
      mem_ack = (i == ack_dly);
      if (mem_ack) mem_rdata = rd;
      rst       = (i == rst_cyc);
      exp_req   = 1'b1;
      exp_stall = 1'b1;
      exp_we    = st;
      exp_addr  = {a[63:3], 3'b000};
      exp_be    = be;
      exp_wdata = wlane;
      if (i == rst_cyc) begin
        next_cycle();
        mem_valid = 1'b0;
        mem_ack   = 1'b1;
        exp_zero  = 1'b1;
        return;
      end
      if (i == fl_cyc) flushed = 1'b1;
      if (i == ack_dly) begin
        next_cycle();
        exp_rv    = ld & ~flushed;
        exp_rdata = rv;
        return;
      end
      if (i == int'(TIMEOUT) - 1) begin
        next_cycle();
        exp_err = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    rst = 1'b1; mem_valid = 1'b0; load_data = 1'b0; store_data = 1'b0; flush = 1'b0;
    funct3 = '0; wmask = '0; addr = '0; wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_req = 1'b0; exp_stall = 1'b0; exp_rv = 1'b0; exp_err = 1'b0; exp_we = 1'b0;
    exp_zero = 1'b1;
    chk_en = 1'b1;

    pin_acc_en = 1'b1; pin_addr = 64'h1000; pin_be = 8'hF0;
    pin_rd_en = 1'b1; pin_rdata = 64'hFFFF_FFFF_8000_0001;
    run_op(1, 0, 3'b010, 8'h00, 64'h1004, 64'h0, 64'h8000_0001_0000_0000, 2, -1, -1);
    settle();

    pin_acc_en = 1'b1; pin_addr = 64'h2000; pin_be = 8'hC0;
    pin_wd_en = 1'b1; pin_wdata = 64'hBEEF_0000_0000_0000;
    run_op(0, 1, 3'b001, 8'h03, 64'h2006, 64'hBEEF, 64'h0, 1, -1, -1);
    settle();

    run_op(1, 0, 3'b011, 8'h00, 64'h3004, 64'h0, 64'h0, 0, -1, -1);
    run_op(1, 0, 3'b101, 8'h00, 64'h4002, 64'h0, 64'h0, 1000, -1, -1);
    run_op(1, 0, 3'b011, 8'h00, 64'h5000, 64'h0, 64'h1122_3344_5566_7788, 2, 1, -1);
    run_op(1, 0, 3'b011, 8'h00, 64'h6000, 64'h0, 64'h0, 1000, -1, 1);
    next_cycle();
    run_op(1, 1, 3'b011, 8'hFF, 64'h7000, 64'h0, 64'h0, 0, -1, -1);
    run_op(0, 1, 3'b010, 8'hFF, 64'h7000, 64'h1234, 64'h0, 0, -1, -1);
    run_op(0, 1, 3'b110, 8'h0F, 64'h7000, 64'h1234, 64'h0, 0, -1, -1);
    run_op(1, 0, 3'b001, 8'h00, 64'h8006, 64'h0, 64'h8001_0000_0000_0000, 0, -1, -1);
    run_op(1, 0, 3'b110, 8'h00, 64'h8004, 64'h0, 64'h8765_4321_0000_0000, 0, -1, -1);
    run_op(1, 0, 3'b101, 8'h00, 64'h8002, 64'h0, 64'h0000_0000_F00D_0000, 0, -1, -1);

    for (int k = 0; k < 300; k++) begin
      bit          ld, st;
      logic [2:0]  f3;
      logic [7:0]  wm;
      logic [63:0] a;
      int          dly, fc;
      ld = 1'($urandom);
      st = ~ld;
      if ($urandom_range(0, 15) == 0) begin
        ld = 1'b1;
        st = 1'b1;
      end
      f3 = 3'($urandom);
      wm = 8'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        case (f3)
          3'b011:  wm = 8'hFF;
          3'b010:  wm = 8'h0F;
          3'b001:  wm = 8'h03;
          default: ;
        endcase
      end
      a = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0) a[2:0] = 3'b000;
      dly = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 4));
      fc  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_op(ld, st, f3, wm, a, {$urandom, $urandom}, {$urandom, $urandom}, dly, fc, -1);
      repeat ($urandom_range(0, 2)) next_cycle();
    end

    settle();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter XLEN, default 64, data and address width.
REQ-002 Parameter TIMEOUT, default 15, max cycles to wait for mem_ack before abort (range 1..255).
REQ-003 Clock and reset: one clock, clk; reset rst is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 mem_valid  input  1  MEM-stage instruction valid.
REQ-007 load_data  input  1  MEM-stage instruction is a load.
REQ-008 store_data  input  1  MEM-stage instruction is a store.
REQ-009 funct3  input  3  access size/sign: 011 LD, 010 LW, 110 LWU, 001 LH, 101 LHU (loads); 011 SD, 010 SW, 001 SH (stores).
REQ-010 wmask  input  8  store byte mask, unshifted (FF, 0F, 03).
REQ-011 addr  input  XLEN  effective address from ALU.
REQ-012 wdata  input  XLEN  store data, unshifted.
REQ-013 flush  input  1  squash current MEM-stage instruction.
REQ-014 mem_req  output  1  memory request, held until mem_ack.
REQ-015 mem_we  output  1  1 = write.
REQ-016 mem_addr  output  XLEN  addr with bits [2:0] cleared.
REQ-017 mem_be  output  8  byte enables.
REQ-018 mem_wdata  output  XLEN  lane-aligned store data.
REQ-019 mem_ack  input  1  memory completion, one-cycle pulse.
REQ-020 mem_rdata  input  XLEN  read doubleword, valid with mem_ack.
REQ-021 stall  output  1  freeze pipeline upstream of MEM.
REQ-022 rdata  output  XLEN  extended load result.
REQ-023 rdata_valid  output  1  one-cycle pulse, rdata valid.
REQ-024 access_err  output  1  one-cycle pulse, access rejected or timed out.

Function
REQ-025 FSM states: IDLE, ACCESS, DONE, ERR.
REQ-026 Launch condition in IDLE: mem_valid & !flush & (load_data ^ store_data).
REQ-027 Byte offset off = addr[2:0]; size = 8/4/2 bytes per funct3.
REQ-028 Reject (IDLE->ERR, no mem_req) on launch when off + size > 8, funct3 unsupported for that direction, or store wmask not matching funct3.
REQ-029 mem_valid & load_data & store_data both high in IDLE -> ERR, no access.
REQ-030 Valid launch: IDLE->ACCESS; addr, off, funct3, direction, be = wmask<<off (stores) or size mask<<off (loads), wdata<<(8*off) registered at the edge.
REQ-031 ACCESS: mem_req=1 and mem_we/mem_addr/mem_be/mem_wdata stable from registers until the mem_ack cycle.
REQ-032 mem_ack in ACCESS -> DONE next edge; mem_req drops in DONE.
REQ-033 Load result: (mem_rdata >> 8*off) truncated to size, sign-extended for LD/LW/LH, zero-extended for LWU/LHU; registered at ack edge.
REQ-034 DONE lasts exactly one cycle: rdata_valid=1 for loads (0 for stores), stall=0, then IDLE unconditionally (no relaunch of the same instruction).
REQ-035 stall = 1 in ACCESS, and in IDLE when the launch condition holds; 0 in DONE and ERR.
REQ-036 Wait counter cleared on entry to ACCESS, increments per cycle without ack; reaching TIMEOUT -> ERR, mem_req dropped.
REQ-037 ERR lasts one cycle: access_err=1, stall=0, then IDLE.
REQ-038 flush in IDLE blocks launch; flush during ACCESS does not abort the request; transaction completes, and rdata_valid is suppressed in DONE.
REQ-039 mem_ack outside ACCESS is ignored.
REQ-040 Load-to-load back-to-back: minimum 3 cycles per access (IDLE, ACCESS, DONE) with zero-wait memory.

Reset
REQ-041 rst at a rising edge: state IDLE, counter 0, mem_req/mem_we/stall/rdata_valid/access_err 0, mem_addr/mem_be/mem_wdata/rdata 0.
REQ-042 rst during ACCESS drops mem_req the next cycle; in-flight result discarded.

Verification
REQ-043 LW addr=0x1004, mem_rdata=0x80000001_00000000, ack after 2 cycles -> mem_addr=0x1000, mem_be=F0, rdata=0xFFFFFFFF_80000001, rdata_valid pulses once.
REQ-044 SH addr=0x2006, wdata=0xBEEF, wmask=03 -> mem_we=1, mem_be=C0, mem_wdata=0xBEEF0000_00000000, no rdata_valid.
REQ-045 LD addr=0x3004 -> access_err pulse, mem_req never asserted, stall high only in the launch cycle.
REQ-046 LHU with no mem_ack -> mem_req held 15 cycles, then access_err, mem_req=0, state IDLE.
REQ-047 LD with flush asserted in 2nd ACCESS cycle, ack in 3rd -> mem_req until ack, rdata_valid stays 0.
REQ-048 rst asserted in ACCESS -> next cycle mem_req=0, stall=0, all outputs zero; late mem_ack ignored.
